// File: rtl/cpu_init_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_init_sequencer
//
// Boot controller for the pipelined CPU core. A go pulse walks the BTB, BHT
// and register-file init ports one entry per cycle (register values come from
// an external init ROM with one cycle of read latency), then releases the
// core via start_switch. While the core runs, a rising edge on EN_NPU launches
// one NPU job with a start/done handshake.
//
// Ports:
//   clk, rst        rising-edge clock; asynchronous active-low reset
//   go              single-cycle request to (re)start initialisation
//   reg_rom_addr    init ROM read address
//   reg_rom_data    init ROM data, valid one cycle after reg_rom_addr
//   btb_*           BTB init address / data / write strobe
//   bht_*           BHT init address / data / write strobe
//   reg_*           register-file init address / data / write strobe
//   init_mode       high while any table is being written (core rst_switch)
//   start_switch    core run enable
//   EN_NPU          NPU request level from the core
//   npu_start       one-cycle NPU launch pulse
//   npu_done        NPU completion pulse
//   busy            high in every state except IDLE and RUN
//   npu_count       completed NPU jobs since last go, saturating at 255
// -----------------------------------------------------------------------------
module cpu_init_sequencer #(
   parameter int          BTB_DEPTH = 256,
   parameter int          BHT_DEPTH = 256,
   parameter logic [39:0] BTB_RESET = 40'h0,
   parameter logic [1:0]  BHT_RESET = 2'b01,
   parameter int          REG_COUNT = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        go,
   output logic [4:0]  reg_rom_addr,
   input  logic [31:0] reg_rom_data,
   output logic [7:0]  btb_addr,
   output logic [39:0] btb_init,
   output logic        btb_we,
   output logic [7:0]  bht_addr,
   output logic [1:0]  bht_init,
   output logic        bht_we,
   output logic [4:0]  reg_addr,
   output logic [31:0] reg_init,
   output logic        reg_we,
   output logic        init_mode,
   output logic        start_switch,
   input  logic        EN_NPU,
   output logic        npu_start,
   input  logic        npu_done,
   output logic        busy,
   output logic [7:0]  npu_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_BTB,
      S_BHT,
      S_REG,
      S_REG_DRAIN,
      S_RUN,
      S_NPU_WAIT
   } state_t;

   localparam logic [7:0] BTB_LAST = 8'(BTB_DEPTH - 1);
   localparam logic [7:0] BHT_LAST = 8'(BHT_DEPTH - 1);
   localparam logic [7:0] REG_LAST = 8'(REG_COUNT - 1);

   state_t     state, state_n;
   logic [7:0] idx, idx_n;          // shared entry counter for all three tables
   logic [7:0] npu_cnt, npu_cnt_n;
   logic       start_q, start_n;    // high during the first NPU_WAIT cycle
   logic       en_npu_q;
   logic       npu_edge;

   assign npu_edge = EN_NPU & ~en_npu_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         idx      <= '0;
         npu_cnt  <= '0;
         start_q  <= 1'b0;
         en_npu_q <= 1'b0;
      end else begin
         state    <= state_n;
         idx      <= idx_n;
         npu_cnt  <= npu_cnt_n;
         start_q  <= start_n;
         en_npu_q <= EN_NPU;
      end
   end

   // NOTE: every signal gets a default before the case so no path leaves a
   // value unassigned, which would otherwise infer a latch.
   always_comb begin
      state_n   = state;
      idx_n     = idx;
      npu_cnt_n = npu_cnt;
      start_n   = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (go) begin
               state_n   = S_BTB;
               idx_n     = '0;
               npu_cnt_n = '0;
            end
         end
         S_BTB: begin
            if (idx == BTB_LAST) begin
               state_n = S_BHT;
               idx_n   = '0;
            end else begin
               idx_n = idx + 8'd1;
            end
         end
         S_BHT: begin
            if (idx == BHT_LAST) begin
               // ROM address 0 goes out in this cycle, so the REG phase starts
               // issuing address 1 while writing entry 0.
               state_n = (REG_COUNT == 1) ? S_REG_DRAIN : S_REG;
               idx_n   = 8'd1;
            end else begin
               idx_n = idx + 8'd1;
            end
         end
         S_REG: begin
            idx_n = idx + 8'd1;
            if (idx == REG_LAST) state_n = S_REG_DRAIN;
         end
         S_REG_DRAIN: begin
            state_n = S_RUN;
            idx_n   = '0;
         end
         S_RUN: begin
            // go has priority; a coincident NPU edge is dropped.
            if (go) begin
               state_n   = S_BTB;
               idx_n     = '0;
               npu_cnt_n = '0;
            end else if (npu_edge) begin
               state_n = S_NPU_WAIT;
               start_n = 1'b1;
            end
         end
         S_NPU_WAIT: begin
            // done is only honoured once the launch pulse has gone out.
            if (npu_done && !start_q) begin
               state_n = S_RUN;
               if (npu_cnt != 8'hFF) npu_cnt_n = npu_cnt + 8'd1;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Output decode: addresses and data are forced to zero outside their phase.
   always_comb begin
      reg_rom_addr = '0;
      btb_addr     = '0;
      btb_init     = '0;
      btb_we       = 1'b0;
      bht_addr     = '0;
      bht_init     = '0;
      bht_we       = 1'b0;
      reg_addr     = '0;
      reg_init     = '0;
      reg_we       = 1'b0;
      init_mode    = 1'b0;
      start_switch = 1'b0;
      busy         = 1'b0;
      unique case (state)
         S_BTB: begin
            btb_addr  = idx;
            btb_init  = BTB_RESET;
            btb_we    = 1'b1;
            init_mode = 1'b1;
            busy      = 1'b1;
         end
         S_BHT: begin
            bht_addr  = idx;
            bht_init  = BHT_RESET;
            bht_we    = 1'b1;
            init_mode = 1'b1;
            busy      = 1'b1;
         end
         S_REG: begin
            reg_rom_addr = idx[4:0];
            reg_addr     = idx[4:0] - 5'd1;
            reg_init     = reg_rom_data;
            reg_we       = 1'b1;
            init_mode    = 1'b1;
            busy         = 1'b1;
         end
         S_REG_DRAIN: begin
            reg_addr  = idx[4:0] - 5'd1;
            reg_init  = reg_rom_data;
            reg_we    = 1'b1;
            init_mode = 1'b1;
            busy      = 1'b1;
         end
         S_RUN: begin
            start_switch = 1'b1;
         end
         S_NPU_WAIT: begin
            start_switch = 1'b1;
            busy         = 1'b1;
         end
         default: ;
      endcase
   end

   assign npu_start = start_q;
   assign npu_count = npu_cnt;

endmodule

// File: tb/tb_cpu_init_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cpu_init_sequencer
//
// Directed bench. Expected table writes and NPU launches are queued when the
// stimulus is issued; a negedge monitor pops and compares each time the DUT
// raises a write strobe or npu_start. Cycle-exact items (latency, reset values,
// handshake state) are checked inline by the stimulus.
// -----------------------------------------------------------------------------
module tb_cpu_init_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        go = 1'b0;
   logic        EN_NPU = 1'b0;
   logic        npu_done = 1'b0;
   logic [31:0] reg_rom_data = '0;
   logic [4:0]  reg_rom_addr;
   logic [7:0]  btb_addr;
   logic [39:0] btb_init;
   logic        btb_we;
   logic [7:0]  bht_addr;
   logic [1:0]  bht_init;
   logic        bht_we;
   logic [4:0]  reg_addr;
   logic [31:0] reg_init;
   logic        reg_we;
   logic        init_mode;
   logic        start_switch;
   logic        npu_start;
   logic        busy;
   logic [7:0]  npu_count;

   always #5 clk = ~clk;

   // Init ROM model: one cycle of read latency.
   always @(posedge clk) reg_rom_data <= 32'hA000_0000 + 32'(reg_rom_addr);

   cpu_init_sequencer dut (
      .clk          (clk),
      .rst          (rst),
      .go           (go),
      .reg_rom_addr (reg_rom_addr),
      .reg_rom_data (reg_rom_data),
      .btb_addr     (btb_addr),
      .btb_init     (btb_init),
      .btb_we       (btb_we),
      .bht_addr     (bht_addr),
      .bht_init     (bht_init),
      .bht_we       (bht_we),
      .reg_addr     (reg_addr),
      .reg_init     (reg_init),
      .reg_we       (reg_we),
      .init_mode    (init_mode),
      .start_switch (start_switch),
      .EN_NPU       (EN_NPU),
      .npu_start    (npu_start),
      .npu_done     (npu_done),
      .busy         (busy),
      .npu_count    (npu_count)
   );

   typedef enum logic [1:0] {K_BTB, K_BHT, K_REG, K_NPU} kind_t;
   typedef struct packed {
      kind_t       kind;
      logic [7:0]  addr;
      logic [63:0] data;
   } txn_t;

   txn_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic compare_pop(input txn_t got);
      txn_t exp;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL unexpected event: kind %0d addr %0d data 0x%0h, expected none",
                  got.kind, got.addr, got.data);
      end else begin
         exp = sb.pop_front();
         if (got !== exp) begin
            errors++;
            $display("FAIL event order: got kind %0d addr %0d data 0x%0h, expected kind %0d addr %0d data 0x%0h",
                     got.kind, got.addr, got.data, exp.kind, exp.addr, exp.data);
         end
      end
   endtask

   function automatic logic outs_zero();
      return ({reg_rom_addr, btb_addr, btb_init, btb_we, bht_addr, bht_init, bht_we,
               reg_addr, reg_init, reg_we, init_mode, start_switch, npu_start, busy,
               npu_count} === '0);
   endfunction

   // Monitor: sample away from the rising edge.
   always @(negedge clk) begin
      int   n;
      txn_t got;
      if (rst) begin
         n = int'(btb_we) + int'(bht_we) + int'(reg_we);
         if (n != 0) begin
            check("single strobe", 64'(n), 64'd1);
            if (btb_we)      got = '{kind: K_BTB, addr: btb_addr, data: 64'(btb_init)};
            else if (bht_we) got = '{kind: K_BHT, addr: bht_addr, data: 64'(bht_init)};
            else             got = '{kind: K_REG, addr: 8'(reg_addr), data: 64'(reg_init)};
            compare_pop(got);
         end
         if (npu_start) compare_pop('{kind: K_NPU, addr: 8'd0, data: 64'd0});
      end
   end

   task automatic push_init();
      for (int i = 0; i < 256; i++) sb.push_back('{kind: K_BTB, addr: 8'(i), data: 64'h0});
      for (int i = 0; i < 256; i++) sb.push_back('{kind: K_BHT, addr: 8'(i), data: 64'h1});
      for (int i = 0; i < 32; i++)
         sb.push_back('{kind: K_REG, addr: 8'(i), data: 64'(32'hA000_0000 + 32'(i))});
   endtask

   // Issue go (optionally with an EN_NPU rise in the same cycle); returns in
   // cycle 1, i.e. #1 after the edge that sampled go.
   task automatic start_init(input bit with_edge);
      push_init();
      @(posedge clk); #1;
      go = 1'b1;
      if (with_edge) EN_NPU = 1'b1;
      @(posedge clk); #1;
      go = 1'b0;
      check("cycle1 btb_we",       64'(btb_we),       64'd1);
      check("cycle1 btb_addr",     64'(btb_addr),     64'd0);
      check("cycle1 init_mode",    64'(init_mode),    64'd1);
      check("cycle1 start_switch", 64'(start_switch), 64'd0);
      check("cycle1 npu_count",    64'(npu_count),    64'd0);
      check("cycle1 npu_start",    64'(npu_start),    64'd0);
   endtask

   // Continue from cycle 1 to cycle 545; optionally pulse go in cycle glitch.
   task automatic finish_init(input int glitch);
      for (int k = 2; k <= 545; k++) begin
         @(posedge clk); #1;
         go = (k == glitch);
         if (k == glitch) check("btb_addr at ignored go", 64'(btb_addr), 64'(k - 1));
         if (k == 544) check("start_switch at 544", 64'(start_switch), 64'd0);
      end
      go = 1'b0;
      check("start_switch at 545", 64'(start_switch), 64'd1);
      check("init_mode in RUN",    64'(init_mode),    64'd0);
      check("busy in RUN",         64'(busy),         64'd0);
      check("all writes seen",     64'(sb.size()),    64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values with go and EN_NPU active.
      rst = 1'b0; go = 1'b1; EN_NPU = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("outputs zero in reset", 64'(outs_zero()), 64'd1);
      go = 1'b0; EN_NPU = 1'b0;
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("outputs zero after release", 64'(outs_zero()), 64'd1);

      // Full initialisation.
      start_init(1'b0);
      finish_init(0);

      // NPU handshake, done 10 cycles after the launch pulse.
      sb.push_back('{kind: K_NPU, addr: 8'd0, data: 64'd0});
      @(posedge clk); #1 EN_NPU = 1'b1;
      @(posedge clk); #1;
      check("npu_start pulse", 64'(npu_start),    64'd1);
      check("busy in NPU_WAIT", 64'(busy),        64'd1);
      check("run kept in NPU",  64'(start_switch), 64'd1);
      repeat (10) @(posedge clk);
      #1;
      check("npu_count before done", 64'(npu_count), 64'd0);
      npu_done = 1'b1;
      @(posedge clk); #1 npu_done = 1'b0;
      check("npu_count after done", 64'(npu_count), 64'd1);
      check("back to RUN",          64'(busy),      64'd0);
      repeat (20) @(posedge clk);    // held level: monitor flags any relaunch
      #1 EN_NPU = 1'b0;
      repeat (2) @(posedge clk);

      // Second job: done during the launch cycle must be ignored.
      sb.push_back('{kind: K_NPU, addr: 8'd0, data: 64'd0});
      #1 EN_NPU = 1'b1;
      @(posedge clk); #1;
      check("second npu_start", 64'(npu_start), 64'd1);
      npu_done = 1'b1;
      @(posedge clk); #1 npu_done = 1'b0;
      check("early done ignored", 64'(busy),      64'd1);
      check("count unchanged",    64'(npu_count), 64'd1);
      repeat (3) @(posedge clk);
      #1 npu_done = 1'b1;
      @(posedge clk); #1 npu_done = 1'b0;
      check("npu_count second", 64'(npu_count), 64'd2);
      check("RUN after second", 64'(busy),      64'd0);
      EN_NPU = 1'b0;
      repeat (2) @(posedge clk);

      // Restart from RUN with a coincident NPU edge, plus an ignored go mid-BTB.
      start_init(1'b1);
      finish_init(101);
      EN_NPU = 1'b0;
      repeat (2) @(posedge clk);

      // Reset in the middle of the BHT phase, then a clean full restart.
      start_init(1'b0);
      for (int k = 2; k <= 307; k++) @(posedge clk);
      #1;
      check("bht_addr before reset", 64'(bht_addr), 64'd50);
      check("bht_we before reset",   64'(bht_we),   64'd1);
      #1 rst = 1'b0;
      #1;
      check("outputs zero mid-BHT reset", 64'(outs_zero()), 64'd1);
      sb.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      start_init(1'b0);
      finish_init(0);

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cpu_init_sequencer.md
Name: cpu_init_sequencer

Overview:
Boot/initialisation controller for the pipelined CPU core. After a go pulse it walks the BTB, BHT and register-file initialisation ports entry by entry. Register contents come from an external init ROM. Once loading finishes it releases the core by asserting start_switch. While the core runs, it services the core's EN_NPU request with a start/done handshake towards the NPU.

Parameters:
BTB_DEPTH  256  number of BTB entries cleared (addresses 0..BTB_DEPTH-1, max 256)
BHT_DEPTH  256  number of BHT entries initialised (max 256)
BTB_RESET  40'h0  value written to every BTB entry
BHT_RESET  2'b01  value written to every BHT entry (weakly not-taken)
REG_COUNT  32  register-file entries loaded from ROM (x0..x31)

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  reset; asynchronous, active-low
go  in  1  single-cycle request to (re)start initialisation
reg_rom_addr  out  5  init ROM read address
reg_rom_data  in  32  init ROM data, valid 1 cycle after address
btb_addr  out  8  BTB init address
btb_init  out  40  BTB init data
btb_we  out  1  BTB init write strobe
bht_addr  out  8  BHT init address
bht_init  out  2  BHT init data
bht_we  out  1  BHT init write strobe
reg_addr  out  5  register-file init address
reg_init  out  32  register-file init data
reg_we  out  1  register-file init write strobe
init_mode  out  1  drives core rst_switch; high while any table is being written
start_switch  out  1  core run enable; core is held in reset while low
EN_NPU  in  1  NPU request level from core
npu_start  out  1  one-cycle NPU launch pulse
npu_done  in  1  NPU completion pulse
busy  out  1  high in any state except IDLE and RUN
npu_count  out  8  completed NPU jobs since last go, saturates at 255

Behaviour:
- Reset (rst low, async): state IDLE. All outputs are 0, including addresses, data, strobes, init_mode, start_switch, npu_start, busy and npu_count. The EN_NPU edge register is cleared.
- FSM states: IDLE, BTB, BHT, REG, REG_DRAIN, RUN, NPU_WAIT.
- IDLE: go -> BTB. npu_count is cleared and init_mode=1 from the next cycle.
- BTB: one write per cycle. btb_we=1, btb_init=BTB_RESET, btb_addr counts 0..BTB_DEPTH-1. After the last address -> BHT.
- BHT: same pattern with bht_we=1, bht_init=BHT_RESET and bht_addr 0..BHT_DEPTH-1. After the last address -> REG, with reg_rom_addr=0 issued in the last BHT cycle.
- REG (ROM pipelined, latency 1): reg_rom_addr is issued in cycle n; reg_addr=n-th index, reg_init=reg_rom_data and reg_we=1 in cycle n+1. After address REG_COUNT-1 has been issued -> REG_DRAIN.
- REG_DRAIN: writes the final entry, then -> RUN.
- Exactly one write strobe is high in any cycle. All strobes are 0 outside BTB/BHT/REG/REG_DRAIN.
- Total time from go to start_switch=1 is BTB_DEPTH+BHT_DEPTH+REG_COUNT+1 cycles after the go cycle (545 with defaults).
- RUN: init_mode=0, start_switch=1.
  - A rising edge on EN_NPU (registered compare) -> NPU_WAIT, with npu_start=1 for exactly the first NPU_WAIT cycle.
  - A level held high does not retrigger; a new 0->1 edge is required.
- NPU_WAIT: start_switch stays 1. npu_done is sampled from the cycle after npu_start. On npu_done: -> RUN and npu_count+1 (saturating at 255).
- go handling:
  - go in BTB/BHT/REG/REG_DRAIN/NPU_WAIT: ignored.
  - go in RUN: -> BTB. start_switch drops to 0 in the same transition, addresses restart at 0 and npu_count clears.
  - go and an EN_NPU edge in the same RUN cycle: go wins; the NPU edge is discarded.
- Reset mid-sequence: immediate return to IDLE. No partial resume; the next go restarts from BTB address 0.
- Address counters never wrap. Terminal compare uses DEPTH-1, so DEPTH=256 ends at 8'hFF.

Test Plan:
- Reset values: hold rst=0, drive go=1 and EN_NPU=1 -> all outputs 0, state IDLE. Release rst with go=0 -> outputs stay 0.
- Full init: pulse go; ROM returns 32'hA000_0000+addr.
  - btb_we high for 256 cycles with addr 0..255 and data 0.
  - Then bht_we high for 256 cycles with data 2'b01.
  - Then reg_we high for 32 cycles with reg_addr k and reg_init 32'hA000_0000+k.
  - start_switch=1 exactly 545 cycles after the go cycle; no cycle has two strobes high.
- NPU handshake: in RUN, raise EN_NPU and hold it.
  - npu_start pulses once.
  - npu_done after 10 cycles -> npu_count=1 and state RUN.
  - No second npu_start until EN_NPU falls and rises again.
- Ignored go: pulse go at BTB address 100 -> the sequence continues uninterrupted and total latency is still 545.
- Restart from RUN: go and an EN_NPU edge in the same cycle -> no npu_start pulse, start_switch falls next cycle, btb_addr restarts at 0, npu_count=0.
- Reset mid-BHT: assert rst at bht_addr 50 -> outputs 0 asynchronously. A following go restarts at btb_addr 0 and all tables are rewritten in full.
